// File: rtl/s2p_deser_if.sv
// Bundle of the deserializer's serial input, control strobes and output handshake.
// master = surrounding environment, slave = the deserializer.
interface s2p_deser_if #(
    parameter int WIDTH = 8
);
    logic             shift_en;
    logic             srial_data_in;
    logic             sync_clr;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
    logic             parity_err;

    modport master (
        output shift_en, srial_data_in, sync_clr, data_ready,
        input  data_out, data_valid, overrun, parity_err
    );

    modport slave (
        input  shift_en, srial_data_in, sync_clr, data_ready,
        output data_out, data_valid, overrun, parity_err
    );
endinterface

// File: rtl/s2p_deser.sv
// Serial-to-parallel deserializer, LSB first, with a single-entry valid/ready output buffer.
// Define S2P_PARITY_EN to expect one parity bit after each word and report parity_err.
module s2p_deser #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    s2p_deser_if.slave    bus
);
    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
`ifdef S2P_PARITY_EN
    localparam logic [1:0] ST_WORD_DONE = ST_PAR;
`else
    localparam logic [1:0] ST_WORD_DONE = ST_IDLE;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    logic             w_take;
    logic             w_complete;
    logic             w_can_load;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_word;

    // sync_clr wins over shift_en, so a bit arriving with it is discarded.
    assign w_take     = bus.shift_en & ~bus.sync_clr;
    assign w_can_load = ~r_valid | bus.data_ready;

    always_comb begin
        w_shreg_nxt = r_shreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_shreg_nxt[i] = bus.srial_data_in;
            end
        end
    end

`ifdef S2P_PARITY_EN
    logic r_perr;
    logic w_perr_nxt;

    assign w_complete = w_take && (r_state == ST_PAR);
    assign w_word     = r_shreg;
    assign w_perr_nxt = bus.srial_data_in ^ (^r_shreg) ^ PARITY_ODD;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_perr <= 1'b0;
        end else if (w_complete && w_can_load) begin
            r_perr <= w_perr_nxt;
        end
    end

    assign bus.parity_err = r_perr;
`else
    logic w_unused_odd;

    assign w_complete     = w_take && (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
    assign w_word         = w_shreg_nxt;
    assign w_unused_odd   = PARITY_ODD;
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
        end else if (bus.sync_clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (bus.shift_en) begin
            case (r_state)
                ST_IDLE, ST_SHIFT: begin
                    r_shreg <= w_shreg_nxt;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_WORD_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Loading and draining in the same cycle keeps data_valid high with the new word.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (w_can_load) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.overrun    = r_overrun;
endmodule
